// File: rtl/addsub_pkg.sv
// addsub_pkg: shared definitions for the pipelined adder/subtractor.
//   clog2     - ceiling log2 for constant expressions
//   calc_wm   - full-precision width, one bit wider than the widest operand
//   ADD / SUB - encodings of the per-sample in_sub select
package addsub_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // One guard bit above the widest operand keeps a+b and a-b exact,
  // including a - (most negative b).
  function automatic int calc_wm(input int wl_a, input int wl_b);
    return ((wl_a > wl_b) ? wl_a : wl_b) + 1;
  endfunction

endpackage

// File: rtl/addsub_reduce.sv
// addsub_reduce: combinational reduction of a WM-bit signed value to WL_OUT bits.
//   full - full-precision two's complement input (WM bits)
//   out  - reduced result (WL_OUT bits): sign-extended, saturated or wrapped
//   ovf  - full did not fit in WL_OUT bits
module addsub_reduce
  import addsub_pkg::*;
#(
  parameter int WM     = 17,
  parameter int WL_OUT = 17,
  parameter bit SAT    = 1'b1
) (
  input  logic [WM-1:0]     full,
  output logic [WL_OUT-1:0] out,
  output logic              ovf
);

  if (WL_OUT > WM) begin : g_extend
    assign out = {{(WL_OUT-WM){full[WM-1]}}, full};
    assign ovf = 1'b0;
  end else if (WL_OUT == WM) begin : g_equal
    assign out = full;
    assign ovf = 1'b0;
  end else begin : g_narrow
    // The value fits exactly when every bit from the MSB down to the
    // output sign position carries the same value.
    localparam int TOP = WM - WL_OUT + 1;
    logic [TOP-1:0] top_bits;
    logic           fits;

    assign top_bits = full[WM-1:WL_OUT-1];
    assign fits     = (&top_bits) | ~(|top_bits);
    assign ovf      = ~fits;

    if (SAT) begin : g_sat
      assign out = fits        ? full[WL_OUT-1:0] :
                   full[WM-1]  ? {1'b1, {(WL_OUT-1){1'b0}}} :
                                 {1'b0, {(WL_OUT-1){1'b1}}};
    end else begin : g_wrap
      assign out = full[WL_OUT-1:0];
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// addsub_pipe: pipelined signed adder/subtractor with valid/ready handshake.
//   clock, resetn         - rising-edge clock, synchronous active-low reset
//   in_valid / in_ready   - input handshake; in_ready = !out_valid | out_ready
//   in_a, in_b, in_sub    - signed operands and select (0: a+b, 1: a-b)
//   out_valid / out_ready - output handshake
//   out, out_ovf          - reduced result and overflow flag
// Latency is STAGES cycles; the whole pipeline advances as one unit.
module addsub_pipe
  import addsub_pkg::*;
#(
  parameter int WL_A   = 16,
  parameter int WL_B   = 16,
  parameter int WL_OUT = 17,
  parameter int STAGES = 2,
  parameter bit SAT    = 1'b1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WL_A-1:0]   in_a,
  input  logic [WL_B-1:0]   in_b,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WL_OUT-1:0] out,
  output logic              out_ovf
);

  localparam int WM = calc_wm(WL_A, WL_B);

  if (WL_OUT < 2 || STAGES < 1 || STAGES > 4 ||
      WL_A < 2 || WL_A > 32 || WL_B < 2 || WL_B > 32) begin : g_bad_params
    $error("addsub_pipe: illegal parameters WL_A=%0d WL_B=%0d WL_OUT=%0d STAGES=%0d",
           WL_A, WL_B, WL_OUT, STAGES);
  end

  // A stalled output freezes every stage, so a single enable serves the chain.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Operands feeding the adder: raw inputs for a single stage, else stage 1.
  logic [WL_A-1:0]   op_a;
  logic [WL_B-1:0]   op_b;
  logic              op_sub;
  logic [WM-1:0]     a_ext;
  logic [WM-1:0]     b_ext;
  logic [WM-1:0]     full;
  logic [WL_OUT-1:0] red_out;
  logic              red_ovf;

  assign a_ext = {{(WM-WL_A){op_a[WL_A-1]}}, op_a};
  assign b_ext = {{(WM-WL_B){op_b[WL_B-1]}}, op_b};
  assign full  = (op_sub == SUB) ? (a_ext - b_ext) : (a_ext + b_ext);

  addsub_reduce #(
    .WM     (WM),
    .WL_OUT (WL_OUT),
    .SAT    (SAT)
  ) u_reduce (
    .full (full),
    .out  (red_out),
    .ovf  (red_ovf)
  );

  if (STAGES == 1) begin : g_one
    logic              v_q;
    logic [WL_OUT-1:0] d_q;
    logic              o_q;

    assign op_a   = in_a;
    assign op_b   = in_b;
    assign op_sub = in_sub;

    // NOTE: data registers are reset along with the valid bits because out
    // and out_ovf must read 0 right after reset, not just be flagged invalid.
    always_ff @(posedge clock) begin
      if (!resetn) begin
        v_q <= 1'b0;
        d_q <= '0;
        o_q <= 1'b0;
      end else if (adv) begin
        v_q <= in_valid;
        d_q <= red_out;
        o_q <= red_ovf;
      end
    end

    assign out_valid = v_q;
    assign out       = d_q;
    assign out_ovf   = o_q;
  end else begin : g_multi
    // Stage 1 holds operands; stages 2..STAGES hold the reduced result.
    logic [WL_A-1:0]   a_q;
    logic [WL_B-1:0]   b_q;
    logic              sub_q;
    logic              v1_q;
    logic [WL_OUT-1:0] d_q [STAGES-1];
    logic [STAGES-2:0] o_q;
    logic [STAGES-2:0] v_q;

    assign op_a   = a_q;
    assign op_b   = b_q;
    assign op_sub = sub_q;

    // NOTE: non-blocking assignments let every stage sample its predecessor's
    // old value at the same edge, which is what makes this a shift chain.
    always_ff @(posedge clock) begin
      if (!resetn) begin
        a_q   <= '0;
        b_q   <= '0;
        sub_q <= 1'b0;
        v1_q  <= 1'b0;
        o_q   <= '0;
        v_q   <= '0;
        for (int i = 0; i < STAGES-1; i++) d_q[i] <= '0;
      end else if (adv) begin
        a_q    <= in_a;
        b_q    <= in_b;
        sub_q  <= in_sub;
        v1_q   <= in_valid;
        d_q[0] <= red_out;
        o_q[0] <= red_ovf;
        v_q[0] <= v1_q;
        for (int i = 1; i < STAGES-1; i++) begin
          d_q[i] <= d_q[i-1];
          o_q[i] <= o_q[i-1];
          v_q[i] <= v_q[i-1];
        end
      end
    end

    assign out_valid = v_q[STAGES-2];
    assign out       = d_q[STAGES-2];
    assign out_ovf   = o_q[STAGES-2];
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// tb_addsub_pipe: three configurations of addsub_pipe driven from one stimulus bus.
//   u_s: 8/8/8  SAT=1 STAGES=2     u_w: 8/8/8  SAT=0 STAGES=2
//   u_x: 8/12/13 SAT=1 STAGES=3
// Each instance has its own scoreboard fed by an arithmetic reference model.
module tb_addsub_pipe;
  import addsub_pkg::*;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [11:0] a_bus = '0;
  logic [11:0] b_bus = '0;

  always #5 clock = ~clock;

  logic        rdy_s, ov_s, ovf_s;
  logic        rdy_w, ov_w, ovf_w;
  logic        rdy_x, ov_x, ovf_x;
  logic [7:0]  out_s, out_w;
  logic [12:0] out_x;

  addsub_pipe #(.WL_A(8), .WL_B(8), .WL_OUT(8), .STAGES(2), .SAT(1'b1)) u_s (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_s),
    .in_a(a_bus[7:0]), .in_b(b_bus[7:0]), .in_sub(in_sub),
    .out_valid(ov_s), .out_ready(out_ready), .out(out_s), .out_ovf(ovf_s));

  addsub_pipe #(.WL_A(8), .WL_B(8), .WL_OUT(8), .STAGES(2), .SAT(1'b0)) u_w (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_w),
    .in_a(a_bus[7:0]), .in_b(b_bus[7:0]), .in_sub(in_sub),
    .out_valid(ov_w), .out_ready(out_ready), .out(out_w), .out_ovf(ovf_w));

  addsub_pipe #(.WL_A(8), .WL_B(12), .WL_OUT(13), .STAGES(3), .SAT(1'b1)) u_x (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(rdy_x),
    .in_a(a_bus[7:0]), .in_b(b_bus), .in_sub(in_sub),
    .out_valid(ov_x), .out_ready(out_ready), .out(out_x), .out_ovf(ovf_x));

  logic [2:0] rdy, ov, ovfv;
  longint     obs [3];
  assign rdy  = {rdy_x, rdy_w, rdy_s};
  assign ov   = {ov_x, ov_w, ov_s};
  assign ovfv = {ovf_x, ovf_w, ovf_s};
  always_comb begin
    obs[0] = longint'($signed(out_s));
    obs[1] = longint'($signed(out_w));
    obs[2] = longint'($signed(out_x));
  end

  typedef struct {
    longint val;
    bit     ovf;
    int     acc;
    bit     lat;
  } exp_t;

  exp_t   sb [3][$];
  int     st_of  [3] = '{2, 2, 3};
  int     wl_of  [3] = '{8, 8, 13};
  bit     sat_of [3] = '{1'b1, 1'b0, 1'b1};
  bit     stall_p [3] = '{1'b0, 1'b0, 1'b0};
  longint held_out [3];
  bit     held_ovf [3];
  int     n_checks = 0;
  int     n_errs = 0;
  int     cyc = 0;
  bit     lat_mode = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs_v, input longint exp_v);
    n_checks++;
    if (obs_v !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs_v, exp_v, $time);
    end
  endtask

  // Result as the plain arithmetic definition states it.
  function automatic exp_t ref_model(input longint a, input longint b, input bit sub,
                                     input int wl, input bit sat);
    exp_t   r;
    longint full, span, hi, lo;
    full  = sub ? a - b : a + b;
    span  = longint'(1) << wl;
    hi    = span / 2 - 1;
    lo    = -(span / 2);
    r.acc = 0;
    r.lat = 1'b0;
    if (full >= lo && full <= hi) begin
      r.val = full;
      r.ovf = 1'b0;
    end else begin
      r.ovf = 1'b1;
      if (sat) r.val = (full > hi) ? hi : lo;
      else begin
        r.val = full & (span - 1);
        if (r.val > hi) r.val = r.val - span;
      end
    end
    return r;
  endfunction

  // Runs at the falling edge: values seen here are what the next rising edge uses.
  task automatic monitor_one(input int i);
    exp_t   e;
    longint ea, eb;
    if (!resetn) begin
      sb[i].delete();
      stall_p[i] = 1'b0;
    end else begin
      if (stall_p[i]) begin
        check($sformatf("hold_valid[%0d]", i), longint'(ov[i]), 1);
        check($sformatf("hold_out[%0d]", i), obs[i], held_out[i]);
        check($sformatf("hold_ovf[%0d]", i), longint'(ovfv[i]), longint'(held_ovf[i]));
      end
      if (ov[i]) begin
        check($sformatf("unexpected_out[%0d]", i), longint'(ov[i]),
              longint'(sb[i].size() > 0));
        if (out_ready && sb[i].size() > 0) begin
          e = sb[i].pop_front();
          check($sformatf("out[%0d]", i), obs[i], e.val);
          check($sformatf("ovf[%0d]", i), longint'(ovfv[i]), longint'(e.ovf));
          if (e.lat && lat_mode)
            check($sformatf("latency[%0d]", i), longint'(cyc + 1 - e.acc), st_of[i]);
        end
      end
      stall_p[i]  = ov[i] && !out_ready;
      held_out[i] = obs[i];
      held_ovf[i] = ovfv[i];
      if (in_valid && rdy[i]) begin
        ea = longint'($signed(a_bus[7:0]));
        eb = (i == 2) ? longint'($signed(b_bus)) : longint'($signed(b_bus[7:0]));
        e = ref_model(ea, eb, in_sub, wl_of[i], sat_of[i]);
        e.acc = cyc + 1;
        e.lat = lat_mode;
        sb[i].push_back(e);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      for (int i = 0; i < 3; i++) monitor_one(i);
    end
  end

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_valid[%0d]", tag, i), longint'(ov[i]), 0);
      check($sformatf("%s_out[%0d]", tag, i), obs[i], 0);
      check($sformatf("%s_ovf[%0d]", tag, i), longint'(ovfv[i]), 0);
      check($sformatf("%s_ready[%0d]", tag, i), longint'(rdy[i]), 1);
    end
  endtask

  task automatic check_empty(input string tag);
    for (int i = 0; i < 3; i++)
      check($sformatf("%s_pending[%0d]", tag, i), longint'(sb[i].size()), 0);
  endtask

  // One sample into an empty pipeline; explicit values plus exact latency.
  task automatic directed(input int a_v, input int b_v, input bit sub_v,
                          input longint es, input bit es_o,
                          input longint ew, input bit ew_o,
                          input longint ex, input bit ex_o);
    a_bus    = a_v[11:0];
    b_bus    = b_v[11:0];
    in_sub   = sub_v;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("dir_s_early", longint'(ov_s), 0);
    check("dir_x_early", longint'(ov_x), 0);
    @(posedge clock); #1;
    check("dir_s_valid", longint'(ov_s), 1);
    check("dir_s_out", obs[0], es);
    check("dir_s_ovf", longint'(ovf_s), longint'(es_o));
    check("dir_w_valid", longint'(ov_w), 1);
    check("dir_w_out", obs[1], ew);
    check("dir_w_ovf", longint'(ovf_w), longint'(ew_o));
    check("dir_x_mid", longint'(ov_x), 0);
    @(posedge clock); #1;
    check("dir_s_after", longint'(ov_s), 0);
    check("dir_x_valid", longint'(ov_x), 1);
    check("dir_x_out", obs[2], ex);
    check("dir_x_ovf", longint'(ovf_x), longint'(ex_o));
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_reset_state("reset");
    resetn = 1'b1;

    //        a      b      sub  u_s        u_w        u_x
    directed( 100,   100,   ADD,  127, 1,   -56, 1,    200, 0);
    directed(-100,  -100,   ADD, -128, 1,    56, 1,   -200, 0);
    directed(   5,  -128,   SUB,  127, 1,  -123, 1,    133, 0);
    directed(   3,     4,   ADD,    7, 0,     7, 0,      7, 0);
    directed(-128,     1,   SUB, -128, 1,   127, 1,   -129, 0);
    directed(-128, -2048,   ADD, -128, 0,  -128, 0,  -2176, 0);

    // 50 back-to-back samples with no back-pressure.
    for (int n = 0; n < 50; n++) begin
      a_bus    = 12'($urandom);
      b_bus    = 12'($urandom);
      in_sub   = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check_empty("stream");

    // Random valid and random back-pressure.
    lat_mode = 1'b0;
    for (int n = 0; n < 300; n++) begin
      a_bus     = 12'($urandom);
      b_bus     = 12'($urandom);
      in_sub    = 1'($urandom);
      in_valid  = ($urandom_range(3) != 0);
      out_ready = 1'($urandom);
      @(posedge clock); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check_empty("stall");

    // Fill with three samples under back-pressure, then reset for one cycle.
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      a_bus    = 12'($urandom);
      b_bus    = 12'($urandom);
      in_sub   = 1'($urandom);
      in_valid = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    resetn   = 1'b0;
    @(posedge clock); #1;
    check_reset_state("midreset");
    resetn    = 1'b1;
    out_ready = 1'b1;
    repeat (10) @(posedge clock);
    #1;
    check_empty("postreset");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
